// File: rtl/mem_arb_pkg.sv
// Shared constants, response-owner encoding and alignment check for the SRAM port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;
  localparam logic [1:0] DSIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {NONE, IRESP, DRESP, DERRR} owner_e;

  // True when a data request cannot be served: illegal size or misaligned half/word.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      DSIZE_BYTE: bad = 1'b0;
      DSIZE_HALF: bad = lo[0];
      DSIZE_WORD: bad = (lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and write replication on issue, read extraction on response.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  wsize,
  input  logic [1:0]  waddr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  input  logic [1:0]  rsize,
  input  logic [1:0]  raddr,
  input  logic [31:0] rlanes,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata;
    case (wsize)
      DSIZE_BYTE: begin
        be     = 4'b0001 << waddr;
        wlanes = {4{wdata[7:0]}};
      end
      DSIZE_HALF: begin
        be     = waddr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
      end
      DSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
  end

  always_comb begin
    shifted = rlanes >> {raddr, 3'b000};
    case (rsize)
      DSIZE_BYTE: rdata = {24'h0, shifted[7:0]};
      DSIZE_HALF: rdata = {16'h0, shifted[15:0]};
      default:    rdata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port SRAM: 1-cycle issue-to-ACK, data priority with
// a bounded data streak so fetch cannot starve.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [31:0]       IADDR,
  output logic              IACK,
  output logic [31:0]       INSTR,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic [31:0]       DWDATA,
  output logic              DACK,
  output logic              DERR,
  output logic [31:0]       DRDATA,
  output logic              MCSN,
  output logic [ADDR_W-1:0] MADDR,
  output logic              MWE,
  output logic [3:0]        MBE,
  output logic [31:0]       MDI,
  input  logic [31:0]       MDO
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

  owner_e            owner_q, owner_d;
  logic              derr_side_q, derr_side_d;
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic [1:0]        dlo_q, dsize_q;
  logic              drw_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       mdi_q;

  logic        dresp, derr_resp;
  logic        i_elig, d_elig, d_bad, d_mem, d_err;
  logic        force_i, d_issue, i_issue;
  logic [3:0]  be;
  logic [31:0] wlanes, rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{IADDR[1:0], IADDR[31:ADDR_W+2], DADDR[31:ADDR_W+2]};

  assign dresp     = (owner_q == DRESP);
  // A data error may be reported alongside a fetch response, hence the side flag.
  assign derr_resp = (owner_q == DERRR) | derr_side_q;
  assign IACK      = (owner_q == IRESP);
  assign DACK      = dresp | derr_resp;
  assign DERR      = derr_resp;

  assign i_elig  = ~RESET & IREQ & ~IACK;
  assign d_elig  = ~RESET & DREQ & ~DACK;
  assign d_bad   = is_bad_access(DSIZE, DADDR[1:0]);
  assign d_mem   = d_elig & ~d_bad;
  assign d_err   = d_elig & d_bad;
  assign force_i = (dstreak_q == SW'(MAX_DSTREAK));
  assign d_issue = d_mem & ~(i_elig & force_i);
  assign i_issue = i_elig & ~d_issue;

  mem_lane_align u_align (
    .wsize  (DSIZE),
    .waddr  (DADDR[1:0]),
    .wdata  (DWDATA),
    .be     (be),
    .wlanes (wlanes),
    .rsize  (dsize_q),
    .raddr  (dlo_q),
    .rlanes (MDO),
    .rdata  (rdata)
  );

  always_comb begin
    owner_d     = NONE;
    derr_side_d = 1'b0;
    if (d_issue) begin
      owner_d = DRESP;
    end else if (i_issue) begin
      owner_d     = IRESP;
      derr_side_d = d_err;
    end else if (d_err) begin
      owner_d = DERRR;
    end
  end

  always_comb begin
    dstreak_d = dstreak_q;
    if (!IREQ || i_issue) begin
      dstreak_d = '0;
    end else if (d_issue && i_elig && !force_i) begin
      dstreak_d = dstreak_q + 1'b1;
    end
  end

  always_comb begin
    MCSN   = ~(d_issue | i_issue);
    MWE    = d_issue & DRW;
    MBE    = d_issue ? be : (i_issue ? 4'b1111 : 4'b0000);
    MADDR  = d_issue ? DADDR[ADDR_W+1:2] : (i_issue ? IADDR[ADDR_W+1:2] : maddr_q);
    MDI    = (d_issue && DRW) ? wlanes : mdi_q;
    INSTR  = IACK ? MDO : 32'h0;
    DRDATA = (dresp && !drw_q) ? rdata : 32'h0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q     <= NONE;
      derr_side_q <= 1'b0;
      dstreak_q   <= '0;
      dlo_q       <= 2'b00;
      dsize_q     <= 2'b00;
      drw_q       <= 1'b0;
      maddr_q     <= '0;
      mdi_q       <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      derr_side_q <= derr_side_d;
      dstreak_q   <= dstreak_d;
      maddr_q     <= MADDR;
      mdi_q       <= MDI;
      if (d_issue) begin
        dlo_q   <= DADDR[1:0];
        dsize_q <= DSIZE;
        drw_q   <= DRW;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a behavioural single-port SRAM.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned MAX_DSTREAK = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              IREQ, DREQ, DRW;
  logic [31:0]       IADDR, DADDR, DWDATA;
  logic [1:0]        DSIZE;
  logic              IACK, DACK, DERR, MCSN, MWE;
  logic [31:0]       INSTR, DRDATA, MDI;
  logic [31:0]       MDO = 32'h0;
  logic [ADDR_W-1:0] MADDR;
  logic [3:0]        MBE;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } dexp_t;

  logic [31:0] iq[$];
  dexp_t       dq[$];
  dexp_t       mon_e;
  logic [31:0] mem[0:(1<<ADDR_W)-1];
  int          n_vec = 0;
  int          n_err = 0;
  logic        got;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .CLK(CLK), .RESET(RESET),
    .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .INSTR(INSTR),
    .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE), .DWDATA(DWDATA),
    .DACK(DACK), .DERR(DERR), .DRDATA(DRDATA),
    .MCSN(MCSN), .MADDR(MADDR), .MWE(MWE), .MBE(MBE), .MDI(MDI), .MDO(MDO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MCSN === 1'b0) begin
      if (MWE) begin
        for (int b = 0; b < 4; b++)
          if (MBE[b]) mem[MADDR][8*b +: 8] <= MDI[8*b +: 8];
      end else begin
        MDO <= mem[MADDR];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (IACK === 1'b1) begin
      if (iq.size() == 0) check("iack_unexpected", 32'd1, 32'd0);
      else check("instr", INSTR, iq.pop_front());
    end
    if (DACK === 1'b1) begin
      if (dq.size() == 0) check("dack_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = dq.pop_front();
        check("derr", {31'h0, DERR}, {31'h0, mon_e.err});
        if (mon_e.chk_rd) check("drdata", DRDATA, mon_e.rd);
      end
    end
  end

  task automatic f_op(input logic [31:0] addr, input logic [31:0] exp_instr);
    iq.push_back(exp_instr);
    @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = addr;
    @(negedge CLK);
    check("f_mcsn", {31'h0, MCSN}, 32'd0);
    check("f_maddr", 32'(MADDR), 32'(addr[ADDR_W+1:2]));
    check("f_mwe", {31'h0, MWE}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge CLK); got = IACK;
    end
    if (!got) check("iack_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    IREQ = 1'b0;
  endtask

  task automatic d_op(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input logic [3:0] exp_be,
                      input logic [31:0] exp_mdi, input logic [31:0] exp_rd);
    dexp_t e;
    e.err = exp_err; e.chk_rd = ~rw; e.rd = exp_rd;
    dq.push_back(e);
    @(posedge CLK); #1;
    DREQ = 1'b1; DRW = rw; DSIZE = size; DADDR = addr; DWDATA = wdata;
    @(negedge CLK);
    check("d_mcsn", {31'h0, MCSN}, {31'h0, exp_err});
    check("d_mbe", {28'h0, MBE}, exp_err ? 32'h0 : {28'h0, exp_be});
    if (!exp_err) begin
      check("d_maddr", 32'(MADDR), 32'(addr[ADDR_W+1:2]));
      check("d_mwe", {31'h0, MWE}, {31'h0, rw});
      if (rw) check("d_mdi", MDI, exp_mdi);
    end
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge CLK); got = DACK;
    end
    if (!got) check("dack_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    DREQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    mem[0]  = 32'hBEEF1234;
    mem[4]  = 32'h12345678;
    mem[16] = 32'hCAFEF00D;

    // Requests held high during reset must not reach the SRAM.
    RESET = 1'b1; IREQ = 1'b1; IADDR = 32'h10; DREQ = 1'b1; DRW = 1'b1;
    DSIZE = 2'b10; DADDR = 32'h40; DWDATA = 32'h55AA55AA;
    repeat (2) @(negedge CLK);
    check("rst_mcsn", {31'h0, MCSN}, 32'd1);
    check("rst_mwe", {31'h0, MWE}, 32'd0);
    check("rst_mbe", {28'h0, MBE}, 32'd0);
    check("rst_maddr", 32'(MADDR), 32'd0);
    check("rst_mdi", MDI, 32'd0);
    check("rst_acks", {29'h0, IACK, DACK, DERR}, 32'd0);
    check("rst_instr", INSTR, 32'd0);
    check("rst_drdata", DRDATA, 32'd0);
    @(posedge CLK); #1;
    IREQ = 1'b0; DREQ = 1'b0; RESET = 1'b0;

    f_op(32'h10, 32'h12345678);

    // Continuous fetch: issue every other cycle, ACKs two cycles apart.
    repeat (3) iq.push_back(32'h12345678);
    @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = 32'h10;
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      check("ispace_iack", {31'h0, IACK}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge CLK); #1;
    IREQ = 1'b0;

    d_op(1'b1, 2'b00, 32'h23, 32'h000000AB, 1'b0, 4'b1000, 32'hABABABAB, 32'h0);
    d_op(1'b0, 2'b00, 32'h23, 32'h0, 1'b0, 4'b1000, 32'h0, 32'h000000AB);
    d_op(1'b0, 2'b00, 32'h22, 32'h0, 1'b0, 4'b0100, 32'h0, 32'h00000000);
    d_op(1'b0, 2'b01, 32'h02, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h0000BEEF);
    d_op(1'b0, 2'b01, 32'h00, 32'h0, 1'b0, 4'b0011, 32'h0, 32'h00001234);
    d_op(1'b1, 2'b01, 32'h2A, 32'h7777C0DE, 1'b0, 4'b1100, 32'hC0DEC0DE, 32'h0);
    d_op(1'b0, 2'b10, 32'h28, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hC0DE0000);
    d_op(1'b1, 2'b10, 32'h30, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    d_op(1'b0, 2'b00, 32'h31, 32'h0, 1'b0, 4'b0010, 32'h0, 32'h000000BE);
    d_op(1'b0, 2'b10, 32'h06, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    d_op(1'b0, 2'b01, 32'h01, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    d_op(1'b1, 2'b11, 32'h00, 32'h1, 1'b1, 4'b0000, 32'h0, 32'h0);
    f_op(32'h4010, 32'h12345678);

    // Both ports held: D,I,D,I... with an ACK every cycle.
    repeat (4) begin
      dq.push_back('{err: 1'b0, chk_rd: 1'b1, rd: 32'hCAFEF00D});
      iq.push_back(32'h12345678);
    end
    @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = 32'h10;
    DREQ = 1'b1; DRW = 1'b0; DSIZE = 2'b10; DADDR = 32'h40;
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      check("il_iack", {31'h0, IACK}, (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
      check("il_dack", {31'h0, DACK}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 7) begin
        @(posedge CLK); #1;
        IREQ = 1'b0; DREQ = 1'b0;
      end
    end

    // Data held continuously; fetch raised on a data issue cycle must still be served.
    repeat (3) dq.push_back('{err: 1'b0, chk_rd: 1'b1, rd: 32'hCAFEF00D});
    iq.push_back(32'h12345678);
    @(posedge CLK); #1;
    DREQ = 1'b1; DRW = 1'b0; DSIZE = 2'b10; DADDR = 32'h40;
    @(posedge CLK); @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = 32'h10;
    got = 1'b0;
    for (int c = 1; c <= int'(MAX_DSTREAK * 2 + 2) && !got; c++) begin
      @(negedge CLK); got = IACK;
    end
    check("starve_iack", {31'h0, got}, 32'd1);
    @(posedge CLK); #1;
    IREQ = 1'b0; DREQ = 1'b0;
    repeat (3) @(posedge CLK);

    // A data error takes no SRAM cycle, so a fetch issues alongside it.
    iq.push_back(32'h12345678);
    dq.push_back('{err: 1'b1, chk_rd: 1'b1, rd: 32'h0});
    @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = 32'h10;
    DREQ = 1'b1; DRW = 1'b0; DSIZE = 2'b10; DADDR = 32'h06;
    @(negedge CLK);
    check("ef_mcsn", {31'h0, MCSN}, 32'd0);
    check("ef_maddr", 32'(MADDR), 32'd4);
    @(negedge CLK);
    check("ef_acks", {30'h0, IACK, DACK}, 32'd3);
    @(posedge CLK); #1;
    IREQ = 1'b0; DREQ = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset right after a fetch issue: response dropped, outputs reset at once.
    @(posedge CLK); #1;
    IREQ = 1'b1; IADDR = 32'h10;
    @(negedge CLK);
    check("mr_issue", {31'h0, MCSN}, 32'd0);
    #1 RESET = 1'b1;
    #1;
    check("mr_mcsn", {31'h0, MCSN}, 32'd1);
    check("mr_maddr", 32'(MADDR), 32'd0);
    check("mr_mbe", {28'h0, MBE}, 32'd0);
    check("mr_acks", {29'h0, IACK, DACK, DERR}, 32'd0);
    check("mr_instr", INSTR, 32'd0);
    IREQ = 1'b0;
    @(negedge CLK);
    check("mr_no_iack", {31'h0, IACK}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);

    check("iq_drained", iq.size(), 32'd0);
    check("dq_drained", dq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
